// File: rtl/rvga_types.sv
// Shared types for the rvga core memory-side blocks.
// Word/cacheline aliases, arbiter FSM state, owner and request bundle.
package rvga_types;

   typedef logic [31:0]  rvga_word;
   typedef logic [127:0] rvga_cacheline;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_RESP
   } rvga_arb_state_e;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } rvga_arb_owner_e;

   typedef struct packed {
      logic          we;
      rvga_word      addr;
      rvga_cacheline wdata;
      logic [15:0]   be;
   } rvga_mem_req;

   // Move a 4-bit word enable into its lane of the 16-bit line enable.
   function automatic logic [15:0] lane_be(
      input logic [3:0] be,
      input logic [1:0] lane
   );
      return 16'(be) << {lane, 2'b00};
   endfunction

endpackage

// File: rtl/rvga_rr_arb2.sv
// Two-requester arbiter, fetch vs data.
// Round-robin on conflict when FAIR != 0, otherwise data wins.
module rvga_rr_arb2 #(
   parameter int FAIR = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req_if,
   input  logic req_dm,
   output logic gnt_if,
   output logic gnt_dm
);

   logic last_dm;
   logic fair_en;

   assign fair_en = (FAIR != 0);

   always_comb begin
      gnt_if = en & req_if & (~req_dm | (fair_en & last_dm));
      gnt_dm = en & req_dm & ~gnt_if;
   end

   // Reset to data so that fetch takes the first conflict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_dm <= 1'b1;
      end else if (gnt_if | gnt_dm) begin
         last_dm <= gnt_dm;
      end
   end

endmodule

// File: rtl/rvga_mem_arbiter.sv
// Fetch/data arbiter for the shared 128-bit cacheline memory port.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP.
module rvga_mem_arbiter
   import rvga_types::*;
#(
   parameter int FAIR = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         if_req_v_i,
   input  logic [31:0]  if_addr_i,
   output logic         if_ready_o,
   output logic         if_resp_v_o,
   output logic [31:0]  if_resp_data_o,
   input  logic         dm_req_v_i,
   input  logic         dm_we_i,
   input  logic [31:0]  dm_addr_i,
   input  logic [31:0]  dm_wdata_i,
   input  logic [3:0]   dm_be_i,
   output logic         dm_ready_o,
   output logic         dm_resp_v_o,
   output logic [31:0]  dm_resp_data_o,
   output logic         mem_req_v_o,
   output logic         mem_we_o,
   output logic [31:0]  mem_addr_o,
   output logic [127:0] mem_wdata_o,
   output logic [15:0]  mem_be_o,
   input  logic         mem_ready_i,
   input  logic         mem_resp_v_i,
   input  logic [127:0] mem_rdata_i
);

   rvga_arb_state_e state_q, state_nxt;
   rvga_arb_owner_e owner_q;
   rvga_mem_req     req_q, req_nxt;
   logic [1:0]      lane_q, lane_nxt;
   rvga_word        rdata_q;
   logic            gnt_if, gnt_dm, grant;
   logic            in_issue, in_resp;
   logic            unused_addr_lsb;

   assign unused_addr_lsb = ^{if_addr_i[1:0], dm_addr_i[1:0]};

   // Gate with rst_n so ready stays low while reset is held.
   rvga_rr_arb2 #(
      .FAIR(FAIR)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (rst_n & (state_q == ARB_IDLE)),
      .req_if(if_req_v_i),
      .req_dm(dm_req_v_i),
      .gnt_if(gnt_if),
      .gnt_dm(gnt_dm)
   );

   assign grant = gnt_if | gnt_dm;

   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         ARB_IDLE:  if (grant) state_nxt = ARB_ISSUE;
         ARB_ISSUE: if (mem_ready_i) state_nxt = ARB_WAIT;
         ARB_WAIT:  if (mem_resp_v_i) state_nxt = ARB_RESP;
         ARB_RESP:  state_nxt = ARB_IDLE;
      endcase
   end

   always_comb begin
      req_nxt  = '0;
      lane_nxt = if_addr_i[3:2];
      req_nxt.addr = {if_addr_i[31:4], 4'h0};
      if (gnt_dm) begin
         lane_nxt      = dm_addr_i[3:2];
         req_nxt.we    = dm_we_i;
         req_nxt.addr  = {dm_addr_i[31:4], 4'h0};
         req_nxt.wdata = {4{dm_wdata_i}};
         req_nxt.be    = dm_we_i ? lane_be(dm_be_i, dm_addr_i[3:2]) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         owner_q <= OWN_IF;
         req_q   <= '0;
         lane_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_nxt;
         if (grant) begin
            req_q   <= req_nxt;
            lane_q  <= lane_nxt;
            owner_q <= gnt_dm ? OWN_DM : OWN_IF;
         end
         if (state_q == ARB_WAIT && mem_resp_v_i) begin
            rdata_q <= req_q.we ? '0
                     : mem_rdata_i[{lane_q, 5'b0} +: 32];
         end
      end
   end

   assign in_issue = (state_q == ARB_ISSUE);
   assign in_resp  = (state_q == ARB_RESP);

   assign if_ready_o = gnt_if;
   assign dm_ready_o = gnt_dm;

   assign mem_req_v_o = in_issue;
   assign mem_we_o    = in_issue & req_q.we;
   assign mem_addr_o  = in_issue ? req_q.addr  : '0;
   assign mem_wdata_o = in_issue ? req_q.wdata : '0;
   assign mem_be_o    = in_issue ? req_q.be    : '0;

   assign if_resp_v_o    = in_resp & (owner_q == OWN_IF);
   assign dm_resp_v_o    = in_resp & (owner_q == OWN_DM);
   assign if_resp_data_o = if_resp_v_o ? rdata_q : '0;
   assign dm_resp_data_o = dm_resp_v_o ? rdata_q : '0;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Bench for rvga_mem_arbiter: directed cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_rvga_mem_arbiter;

   logic         clk;
   logic         rst_n;
   logic         if_req_v_i;
   logic [31:0]  if_addr_i;
   logic         if_ready_o, if_resp_v_o;
   logic [31:0]  if_resp_data_o;
   logic         dm_req_v_i, dm_we_i;
   logic [31:0]  dm_addr_i, dm_wdata_i;
   logic [3:0]   dm_be_i;
   logic         dm_ready_o, dm_resp_v_o;
   logic [31:0]  dm_resp_data_o;
   logic         mem_req_v_o, mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [127:0] mem_wdata_o;
   logic [15:0]  mem_be_o;
   logic         mem_ready_i, mem_resp_v_i;
   logic [127:0] mem_rdata_i;

   logic         f0_if_ready, f0_if_resp_v, f0_dm_ready, f0_dm_resp_v;
   logic [31:0]  f0_if_rdata, f0_dm_rdata;
   logic         f0_mem_req_v, f0_mem_we;
   logic [31:0]  f0_mem_addr;
   logic [127:0] f0_mem_wdata;
   logic [15:0]  f0_mem_be;

   int n_chk = 0;
   int n_fail = 0;

   rvga_mem_arbiter #(.FAIR(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_v_i(if_req_v_i), .if_addr_i(if_addr_i),
      .if_ready_o(if_ready_o), .if_resp_v_o(if_resp_v_o),
      .if_resp_data_o(if_resp_data_o),
      .dm_req_v_i(dm_req_v_i), .dm_we_i(dm_we_i),
      .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_be_i(dm_be_i), .dm_ready_o(dm_ready_o),
      .dm_resp_v_o(dm_resp_v_o), .dm_resp_data_o(dm_resp_data_o),
      .mem_req_v_o(mem_req_v_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
      .mem_resp_v_i(mem_resp_v_i), .mem_rdata_i(mem_rdata_i)
   );

   // Data-priority instance: both sides always requesting, ideal memory.
   rvga_mem_arbiter #(.FAIR(0)) u_dut_f0 (
      .clk(clk), .rst_n(rst_n),
      .if_req_v_i(1'b1), .if_addr_i(32'h0000_0040),
      .if_ready_o(f0_if_ready), .if_resp_v_o(f0_if_resp_v),
      .if_resp_data_o(f0_if_rdata),
      .dm_req_v_i(1'b1), .dm_we_i(1'b0),
      .dm_addr_i(32'h0000_0080), .dm_wdata_i(32'h0),
      .dm_be_i(4'h0), .dm_ready_o(f0_dm_ready),
      .dm_resp_v_o(f0_dm_resp_v), .dm_resp_data_o(f0_dm_rdata),
      .mem_req_v_o(f0_mem_req_v), .mem_we_o(f0_mem_we),
      .mem_addr_o(f0_mem_addr), .mem_wdata_o(f0_mem_wdata),
      .mem_be_o(f0_mem_be), .mem_ready_i(1'b1),
      .mem_resp_v_i(1'b1), .mem_rdata_i({4{32'h1234_5678}})
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Transaction-level model: one outstanding request, phases as flags.
   bit          m_busy, m_issue, m_wait, m_resp;
   bit          m_owner_dm, m_last_dm;
   bit          m_we;
   logic [31:0] m_addr, m_word;
   logic [127:0] m_wdata;
   logic [15:0] m_be;
   int          m_lane;
   bit          if_acc, dm_acc;
   int          resp_cnt = 0;
   bit          grant_log[$];
   int          f0_if_cnt = 0, f0_dm_cnt = 0, f0_ifresp_cnt = 0;

   always @(negedge clk) begin
      bit e_if, e_dm;
      if (!rst_n) begin
         m_busy = 0; m_issue = 0; m_wait = 0; m_resp = 0;
         m_last_dm = 1;
         if_acc = 0; dm_acc = 0;
         chk("reset_outs",
             {if_ready_o, if_resp_v_o, if_resp_data_o,
              dm_ready_o, dm_resp_v_o, dm_resp_data_o,
              mem_req_v_o, mem_we_o, mem_addr_o, mem_be_o}, '0);
         chk("reset_wdata", mem_wdata_o, '0);
      end else begin
         e_if = !m_busy && if_req_v_i && (!dm_req_v_i || m_last_dm);
         e_dm = !m_busy && dm_req_v_i && !e_if;
         chk("ready", {if_ready_o, dm_ready_o}, {e_if, e_dm});
         chk("mem_req_v", mem_req_v_o, m_issue);
         if (m_issue) begin
            chk("mem_we", mem_we_o, m_we);
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_be", mem_be_o, m_be);
            if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
         end
         chk("resp_v", {if_resp_v_o, dm_resp_v_o},
             {m_resp && !m_owner_dm, m_resp && m_owner_dm});
         if (m_resp)
            chk("resp_data",
                m_owner_dm ? dm_resp_data_o : if_resp_data_o, m_word);
         resp_cnt += int'(if_resp_v_o) + int'(dm_resp_v_o);
         if_acc = if_req_v_i & if_ready_o;
         dm_acc = dm_req_v_i & dm_ready_o;
         if (if_ready_o | dm_ready_o) grant_log.push_back(dm_ready_o);
         // advance the model across the coming edge
         if (m_resp) begin
            m_resp = 0; m_busy = 0;
         end else if (m_wait && mem_resp_v_i) begin
            m_wait = 0; m_resp = 1;
            m_word = m_we ? 32'h0 : mem_rdata_i[32*m_lane +: 32];
         end else if (m_issue && mem_ready_i) begin
            m_issue = 0; m_wait = 1;
         end
         if (e_if || e_dm) begin
            m_busy = 1; m_issue = 1;
            m_owner_dm = e_dm; m_last_dm = e_dm;
            if (e_dm) begin
               m_we = dm_we_i;
               m_addr = dm_addr_i & 32'hFFFF_FFF0;
               m_lane = int'(dm_addr_i[3:2]);
               m_wdata = {dm_wdata_i, dm_wdata_i, dm_wdata_i, dm_wdata_i};
               m_be = dm_we_i ? (16'(dm_be_i) << (4 * m_lane)) : 16'h0;
            end else begin
               m_we = 0;
               m_addr = if_addr_i & 32'hFFFF_FFF0;
               m_lane = int'(if_addr_i[3:2]);
               m_wdata = '0;
               m_be = 16'h0;
            end
         end
      end
      if (rst_n) begin
         f0_if_cnt += int'(f0_if_ready);
         f0_dm_cnt += int'(f0_dm_ready);
         f0_ifresp_cnt += int'(f0_if_resp_v);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   localparam logic [127:0] LINE =
      {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};

   initial begin
      int r0;
      logic [3:0] gvec;
      rst_n = 0;
      if_req_v_i = 0; if_addr_i = 0;
      dm_req_v_i = 0; dm_we_i = 0; dm_addr_i = 0;
      dm_wdata_i = 0; dm_be_i = 0;
      mem_ready_i = 0; mem_resp_v_i = 0; mem_rdata_i = '0;
      repeat (3) tick();
      rst_n = 1;
      tick();

      // fetch alone
      if_req_v_i = 1; if_addr_i = 32'h0000_0108; mem_ready_i = 1;
      @(negedge clk) chk("t1_if_ready", if_ready_o, 1);
      tick();
      if_req_v_i = 0;
      @(negedge clk) chk("t1_mem_addr", mem_addr_o, 32'h100);
      chk("t1_mem_we", {mem_req_v_o, mem_we_o}, 2'b10);
      tick();
      mem_resp_v_i = 1; mem_rdata_i = LINE;
      tick();
      mem_resp_v_i = 0;
      @(negedge clk) chk("t1_if_resp", {if_resp_v_o, if_resp_data_o},
                         {1'b1, 32'hCCCC_CCCC});
      tick(); tick();

      // store byte
      dm_req_v_i = 1; dm_we_i = 1; dm_addr_i = 32'h0000_020C;
      dm_be_i = 4'b0010; dm_wdata_i = 32'h0000_5A00;
      @(negedge clk) chk("t2_dm_ready", dm_ready_o, 1);
      tick();
      dm_req_v_i = 0;
      @(negedge clk) chk("t2_mem_be", mem_be_o, 16'h2000);
      chk("t2_mem_addr", mem_addr_o, 32'h200);
      chk("t2_mem_we", mem_we_o, 1);
      chk("t2_mem_wdata", mem_wdata_o, {4{32'h0000_5A00}});
      tick();
      mem_resp_v_i = 1; mem_rdata_i = LINE;
      tick();
      mem_resp_v_i = 0;
      @(negedge clk) chk("t2_dm_resp", {dm_resp_v_o, dm_resp_data_o},
                         {1'b1, 32'h0});
      tick(); tick();

      // conflict, fair
      pulse_reset();
      grant_log.delete();
      if_req_v_i = 1; if_addr_i = 32'h0000_0010;
      dm_req_v_i = 1; dm_we_i = 0; dm_addr_i = 32'h0000_0024;
      mem_ready_i = 1; mem_resp_v_i = 1;
      repeat (17) tick();
      if_req_v_i = 0; dm_req_v_i = 0;
      repeat (6) tick();
      mem_resp_v_i = 0;
      chk("t3_grant_cnt", grant_log.size() >= 4, 1);
      gvec = 4'hF;
      if (grant_log.size() >= 4)
         gvec = {grant_log[0], grant_log[1], grant_log[2], grant_log[3]};
      chk("t3_grant_order", gvec, 4'b0101);

      // backpressure with spurious responses
      mem_ready_i = 0; mem_resp_v_i = 1;
      r0 = resp_cnt;
      tick(); tick();
      mem_resp_v_i = 0;
      dm_req_v_i = 1; dm_we_i = 1; dm_addr_i = 32'h0000_0304;
      dm_be_i = 4'b1100; dm_wdata_i = 32'hABCD_0000;
      tick();
      dm_req_v_i = 0; mem_resp_v_i = 1;
      tick(); tick();
      mem_resp_v_i = 0;
      repeat (3) tick();
      chk("t4_be_stall", mem_be_o, 16'h00C0);
      chk("t4_addr_stall", mem_addr_o, 32'h300);
      mem_ready_i = 1;
      tick();
      mem_ready_i = 0;
      repeat (3) tick();
      mem_resp_v_i = 1;
      tick();
      mem_resp_v_i = 0;
      repeat (3) tick();
      chk("t4_pulses", resp_cnt - r0, 1);

      // reset while waiting on memory
      if_req_v_i = 1; if_addr_i = 32'h0000_0004; mem_ready_i = 1;
      tick();
      if_req_v_i = 0;
      tick();
      mem_ready_i = 0;
      tick();
      chk("t5_in_wait", mem_req_v_o, 0);
      #2 rst_n = 0;
      #1;
      chk("t5_async_outs",
          {if_ready_o, if_resp_v_o, if_resp_data_o, dm_ready_o,
           dm_resp_v_o, mem_req_v_o, mem_we_o, mem_addr_o, mem_be_o}, '0);
      tick();
      rst_n = 1;
      r0 = resp_cnt;
      mem_resp_v_i = 1;
      tick(); tick();
      mem_resp_v_i = 0;
      tick(); tick();
      chk("t5_no_resp", resp_cnt - r0, 0);
      if_req_v_i = 1; if_addr_i = 32'h0000_000C; mem_ready_i = 1;
      tick();
      if_req_v_i = 0;
      tick();
      mem_resp_v_i = 1; mem_rdata_i = LINE;
      tick();
      mem_resp_v_i = 0;
      @(negedge clk) chk("t5_if_resp", {if_resp_v_o, if_resp_data_o},
                         {1'b1, 32'hDDDD_DDDD});
      tick(); tick();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if (!if_req_v_i || if_acc) begin
            if_req_v_i = ($urandom % 3) == 0;
            if_addr_i = $urandom;
         end
         if (!dm_req_v_i || dm_acc) begin
            dm_req_v_i = ($urandom % 3) == 0;
            dm_we_i = $urandom % 2;
            dm_addr_i = $urandom;
            dm_wdata_i = $urandom;
            dm_be_i = 4'($urandom);
         end
         mem_ready_i = $urandom % 2;
         mem_resp_v_i = ($urandom % 3) == 0;
         mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      if_req_v_i = 0; dm_req_v_i = 0;
      mem_ready_i = 1; mem_resp_v_i = 1;
      repeat (8) tick();

      chk("f0_if_ready", f0_if_cnt, 0);
      chk("f0_if_resp", f0_ifresp_cnt, 0);
      chk("f0_dm_grants", f0_dm_cnt >= 100, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rvga_mem_arbiter.md
# rvga_mem_arbiter

Shares the single 128-bit cacheline memory port between the fetch stage (word reads) and the memory stage (word loads/stores). Requests are granted one at a time, round-robin on conflict, and tracked through issue and response phases by a small FSM. Word reads are extracted from the returned cacheline. Word/byte writes are placed into the correct cacheline lane with a 16-bit byte enable.

## Interface
Parameters:
- FAIR, default 1: 1 = round-robin on conflict; 0 = data port always wins.

Ports (clock, reset first):
- clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req_v_i  in  1  fetch request valid
- if_addr_i  in  32  fetch byte address (rvga_word)
- if_ready_o  out  1  fetch request accepted this cycle
- if_resp_v_o  out  1  fetch data valid, one-cycle pulse
- if_resp_data_o  out  32  fetched word
- dm_req_v_i  in  1  data request valid
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  32  data byte address
- dm_wdata_i  in  32  store word, already byte-lane aligned
- dm_be_i  in  4  store byte enables
- dm_ready_o  out  1  data request accepted this cycle
- dm_resp_v_o  out  1  load data valid / store acknowledge, one-cycle pulse
- dm_resp_data_o  out  32  loaded word; 0 for stores
- mem_req_v_o  out  1  memory request valid
- mem_we_o  out  1  memory write
- mem_addr_o  out  32  line-aligned address, bits [3:0] = 0
- mem_wdata_o  out  128  write line (rvga_cacheline)
- mem_be_o  out  16  write byte enables; 0 on reads
- mem_ready_i  in  1  memory accepts request
- mem_resp_v_i  in  1  read data valid / write acknowledge
- mem_rdata_i  in  128  read line

## Operation
- FSM states:
  - IDLE: arbitrate. If any req_v, assert the winner's ready_o, latch the winner's request and owner, and go to ISSUE.
  - ISSUE: hold mem_req_v_o=1 with latched fields. On mem_ready_i, go to WAIT.
  - WAIT: on mem_resp_v_i, capture the selected word into the response register and go to RESP.
  - RESP: pulse the owner's resp_v_o, then go to IDLE.
- Arbitration:
  - FAIR=1: on conflict, grant the requester not granted last. A last_grant register updates on every grant; reset value = data, so fetch wins the first conflict.
  - FAIR=0: data always wins on conflict.
  - A single requester is always granted.
- Word select: lane = addr[3:2]. Read data = mem_rdata_i[32*lane +: 32].
- Writes:
  - mem_wdata_o = store word replicated into all four lanes.
  - mem_be_o = dm_be_i << (4*lane).
  - addr[1:0] ignored.
- Fetch requests are always reads.
- mem_resp_v_i is ignored outside WAIT. mem_ready_i is ignored outside ISSUE.
- Non-owner ready_o and resp_v_o stay 0 throughout a transaction.

## Timing
- Reset: state=IDLE, last_grant=data; all outputs 0, including ready_o, resp_v_o, mem_req_v_o, mem_be_o and data buses.
- Request handshake: req_v & ready_o in the same cycle = accepted. ready_o is combinational from req_v in IDLE. Requesters hold req_v and fields until accepted.
- Memory handshake: mem fields are stable from ISSUE entry until mem_ready_i.
- Minimum latency: accept at cycle N; ISSUE at N+1 (mem_ready_i=1); mem_resp_v_i at N+2; resp_v_o at N+3; next accept at N+4.
- Reset asserted mid-transaction: immediate return to IDLE, outputs 0, in-flight transaction dropped.

## Structure
- Add to rvga_types:
  - rvga_arb_state_e enum (IDLE, ISSUE, WAIT, RESP).
  - rvga_mem_req struct (we, addr, wdata, be).
  - rvga_arb_owner_e enum (IF, DM).
- One sub-module: rvga_rr_arb2, a two-requester arbiter with last_grant register and FAIR parameter.

## Test plan
- Fetch alone:
  - Stimulus: if_addr=0x0000_0108; mem_rdata lanes = {0xDDDD_DDDD, 0xCCCC_CCCC, 0xBBBB_BBBB, 0xAAAA_AAAA} (lane3..lane0).
  - Required: mem_addr=0x100, mem_we=0, if_resp_data=0xCCCC_CCCC at cycle N+3.
- Store byte:
  - Stimulus: dm_addr=0x20C, be=4'b0010, wdata=0x0000_5A00.
  - Required: mem_be=16'h2000, mem_addr=0x200, mem_we=1, dm_resp_v pulse with data 0.
- Conflict with FAIR=1:
  - Stimulus: both request continuously after reset.
  - Required: grants alternate IF, DM, IF, DM; each resp_v goes only to its owner.
- Conflict with FAIR=0:
  - Stimulus: both request continuously.
  - Required: DM granted every time; if_ready stays 0.
- Backpressure:
  - Stimulus: mem_ready_i low for 5 cycles, then mem_resp_v_i delayed 3 cycles; spurious mem_resp_v_i asserted during IDLE.
  - Required: request fields stable throughout; spurious response ignored; exactly one resp_v pulse.
- Reset in WAIT:
  - Stimulus: rst_n low for 1 cycle while in WAIT.
  - Required: all outputs 0 asynchronously; no resp_v after release; next request served normally.
